// File: rtl/caster_pkg.sv
// Shared types and sizing for the waveform LUT loader.
package caster_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck
    } wvfm_state_e;

    localparam int unsigned WVFM_ABITS = 12;
    localparam int unsigned WVFM_DBITS = 8;
    localparam int unsigned WVFM_BYTES = 4096;

endpackage

// File: rtl/wvfm_loader.sv
// Streams a host waveform table into the LUT write port and validates it with a
// trailing checksum byte; the LUT is only written while the display pipeline grants access.
module wvfm_loader
    import caster_pkg::*;
#(
    parameter int unsigned ABITS   = WVFM_ABITS,
    parameter int unsigned DBITS   = WVFM_DBITS,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             wr_allow,
    input  logic [DBITS-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             we,
    output logic [ABITS-1:0] addr,
    output logic [DBITS-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             lut_valid
);

    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    wvfm_state_e      state_q, state_d;
    logic [ABITS:0]   idx_q, idx_d;
    logic [DBITS-1:0] sum_q, sum_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             we_q, we_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [DBITS-1:0] din_q, din_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             lut_valid_q, lut_valid_d;

    logic             hs;
    logic [DBITS-1:0] sum_chk;

    // start/abort steal the handshake so a restarting cycle never writes a stale byte
    assign s_ready = (state_q != StIdle) && wr_allow && !start && !abort;
    assign hs      = s_valid && s_ready;
    assign sum_chk = sum_q + s_data;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        done_d      = 1'b0;
        err_d       = err_q;
        lut_valid_d = lut_valid_q;

        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d     = StLoad;
                    idx_d       = '0;
                    sum_d       = '0;
                    tmo_d       = '0;
                    err_d       = 1'b0;
                    lut_valid_d = 1'b0;
                end
            end
            StLoad, StCheck: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (start) begin
                    state_d     = StLoad;
                    idx_d       = '0;
                    sum_d       = '0;
                    tmo_d       = '0;
                    err_d       = 1'b0;
                    lut_valid_d = 1'b0;
                end else if (hs) begin
                    tmo_d = '0;
                    if (state_q == StLoad) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ABITS-1:0];
                        din_d   = s_data;
                        sum_d   = sum_chk;
                        idx_d   = idx_q + (ABITS + 1)'(1);
                        state_d = idx_d[ABITS] ? StCheck : StLoad;
                    end else begin
                        state_d = StIdle;
                        if (sum_chk == '0) begin
                            done_d      = 1'b1;
                            lut_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (wr_allow) begin
                    // stall time only accrues while the host could actually have been served
                    if (tmo_q == TmoLast) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lut_valid_q <= 1'b1;  // SRAM powers up holding the default waveform
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lut_valid_q <= lut_valid_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign din       = din_q;
    assign done      = done_q;
    assign err       = err_q;
    assign lut_valid = lut_valid_q;
    assign busy      = (state_q != StIdle);

endmodule
